// File: rtl/clock_divider_bank_if.sv
// Configuration port of the clock divider bank: request, accept/reject status, per-channel pending flags.
// Latency: none inside the interface; it only bundles wires.
// Backpressure: cfg_ready drops while the addressed channel still holds an unapplied shadow config.
interface clock_divider_bank_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CHAN_W-1:0]   cfg_chan;
    logic [WIDTH-1:0]    cfg_div;
    logic [WIDTH-1:0]    cfg_high;
    logic                cfg_error;
    logic [CHANNELS-1:0] pending;

    // Requester side
    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_div,
        output cfg_high,
        input  cfg_ready,
        input  cfg_error,
        input  pending
    );

    // Divider bank side
    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_div,
        input  cfg_high,
        output cfg_ready,
        output cfg_error,
        output pending
    );
endinterface

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable divider: per-channel divided clock and one-cycle tick, phase-aligned by sync.
// Latency: clk_out/tick are registered, one clk_in cycle behind the counter; new configs take effect at the period boundary.
// Backpressure: cfg_ready is low while the target channel has a pending shadow config; requester holds the request.
module clock_divider_bank #(
    parameter int               CHANNELS     = 4,
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DIV  = 100000000,
    parameter logic [WIDTH-1:0] DEFAULT_HIGH = DEFAULT_DIV / 2
) (
    input  logic                       clk_in,
    input  logic                       rst_n,
    input  logic [CHANNELS-1:0]        en,
    input  logic                       sync,
    clock_divider_bank_if.slave        cfg,
    output logic [CHANNELS-1:0]        clk_out,
    output logic [CHANNELS-1:0]        tick
);

    localparam logic [31:0]      NUM_CH = 32'(CHANNELS);
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [31:0]         chan_idx;
    logic                chan_ok;
    logic                sel_pending;
    logic                cfg_fire;
    logic                cfg_bad;
    logic                cfg_take;
    logic                cfg_error_q;
    logic [CHANNELS-1:0] pending_vec;

    assign chan_idx = 32'(cfg.cfg_chan);
    assign chan_ok  = (chan_idx < NUM_CH);

    // Pending flag of the addressed channel; an out-of-range index matches nothing and reads as 0
    always_comb begin
        sel_pending = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_idx == 32'(i)) begin
                sel_pending = pending_vec[i];
            end
        end
    end

    // Out-of-range requests are accepted (ready=1) so they can be rejected with an error pulse
    assign cfg.cfg_ready = !sel_pending;
    assign cfg_fire      = cfg.cfg_valid && !sel_pending;
    assign cfg_bad       = (cfg.cfg_div == '0) || (cfg.cfg_high > cfg.cfg_div) || !chan_ok;
    assign cfg_take      = cfg_fire && !cfg_bad;

    // Error pulse: high for exactly the cycle after a rejected request was accepted
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= cfg_fire && cfg_bad;
        end
    end

    assign cfg.cfg_error = cfg_error_q;
    assign cfg.pending   = pending_vec;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div_a;
        logic [WIDTH-1:0] high_a;
        logic [WIDTH-1:0] div_s;
        logic [WIDTH-1:0] high_s;
        logic [WIDTH-1:0] next_high;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             wrap;
        logic             apply;
        logic             take;

        // >= rather than == so a counter beyond the period still returns to 0
        assign wrap      = (cnt >= (div_a - ONE));
        // Shadow is swapped in at a period boundary, a sync edge or any disabled edge
        assign apply     = pend && (sync || !en[g] || wrap);
        assign take      = cfg_take && (chan_idx == 32'(g));
        // High time in effect after this edge, used for the clk_out value written on sync
        assign next_high = apply ? high_s : high_a;

        // Active/shadow configuration registers and the pending flag
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                div_a  <= DEFAULT_DIV;
                high_a <= DEFAULT_HIGH;
                div_s  <= '0;
                high_s <= '0;
                pend   <= 1'b0;
            end else if (apply) begin
                div_a  <= div_s;
                high_a <= high_s;
                pend   <= 1'b0;
            end else if (take) begin
                div_s  <= cfg.cfg_div;
                high_s <= cfg.cfg_high;
                pend   <= 1'b1;
            end
        end

        // Period counter with registered divided clock and tick; sync overrides counting
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (sync) begin
                cnt    <= '0;
                tick_q <= 1'b0;
                clk_q  <= en[g] && (next_high != '0);
            end else if (!en[g]) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt    <= wrap ? '0 : (cnt + ONE);
                clk_q  <= (cnt < high_a);
                tick_q <= wrap;
            end
        end

        assign clk_out[g]     = clk_q;
        assign tick[g]        = tick_q;
        assign pending_vec[g] = pend;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank, 3-channel build with a 10-cycle default period.
// Latency: outputs are sampled 1 time unit after each rising clk_in edge.
// Backpressure: config requests are driven only when the addressed channel is expected to be ready.
module tb_clock_divider_bank;

    localparam int CH = 3;
    localparam int W  = 32;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic [CH-1:0] en     = '0;
    logic          sync   = 1'b0;
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;

    int err_cnt = 0;
    int chk_cnt = 0;

    clock_divider_bank_if #(.CHANNELS(CH), .WIDTH(W)) cfg_if ();

    clock_divider_bank #(
        .CHANNELS     (CH),
        .WIDTH        (W),
        .DEFAULT_DIV  (10),
        .DEFAULT_HIGH (5)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .sync    (sync),
        .cfg     (cfg_if),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input int chan, input int div, input int high);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_chan  = 2'(chan);
        cfg_if.cfg_div   = 32'(div);
        cfg_if.cfg_high  = 32'(high);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  pre;
        logic b;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_chan  = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_high  = '0;

        // Reset state
        repeat (3) step();
        chk("rst_clk_out", clk_out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_pending", cfg_if.pending, 0);
        chk("rst_cfg_error", cfg_if.cfg_error, 0);
        chk("rst_cfg_ready", cfg_if.cfg_ready, 1);

        // Default period 10, high 5 on all channels
        rst_n = 1'b1;
        en    = 3'b111;
        for (int n = 1; n <= 20; n++) begin
            step();
            b = (((n - 1) % 10) < 5);
            chk($sformatf("t1_clk_n%0d", n), clk_out, {b, b, b});
            b = (((n - 1) % 10) == 9);
            chk($sformatf("t1_tick_n%0d", n), tick, {b, b, b});
        end

        // Reconfigure ch0 at cnt=3 to div=4 high=1; old period completes first
        repeat (3) step();
        send(0, 4, 1);
        chk("t2_ready_before", cfg_if.cfg_ready, 1);
        for (int n = 24; n <= 30; n++) begin
            step();
            if (n == 24) cfg_if.cfg_valid = 1'b0;
            pre = n - 21;
            chk($sformatf("t2_old_clk_n%0d", n), clk_out[0], (pre < 5));
            chk($sformatf("t2_old_tick_n%0d", n), tick[0], (pre == 9));
            chk($sformatf("t2_pending_n%0d", n), cfg_if.pending[0], (n < 30));
            chk($sformatf("t2_ready_n%0d", n), cfg_if.cfg_ready, (n == 30));
        end
        for (int m = 1; m <= 8; m++) begin
            step();
            pre = (m - 1) % 4;
            chk($sformatf("t2_new_clk_m%0d", m), clk_out[0], (pre == 0));
            chk($sformatf("t2_new_tick_m%0d", m), tick[0], (pre == 3));
        end

        // Rejected requests: div=0, high>div, channel out of range
        send(1, 0, 0);
        chk("t3a_ready", cfg_if.cfg_ready, 1);
        step();
        chk("t3a_error", cfg_if.cfg_error, 1);
        chk("t3a_pending", cfg_if.pending, 0);
        cfg_if.cfg_valid = 1'b0;
        step();
        chk("t3a_error_clear", cfg_if.cfg_error, 0);

        send(1, 5, 6);
        step();
        chk("t3b_error", cfg_if.cfg_error, 1);
        chk("t3b_pending", cfg_if.pending, 0);
        cfg_if.cfg_valid = 1'b0;
        step();
        chk("t3b_error_clear", cfg_if.cfg_error, 0);

        send(3, 4, 1);
        chk("t3c_ready_oor", cfg_if.cfg_ready, 1);
        step();
        chk("t3c_error", cfg_if.cfg_error, 1);
        chk("t3c_pending", cfg_if.pending, 0);
        cfg_if.cfg_valid = 1'b0;
        step();
        chk("t3c_error_clear", cfg_if.cfg_error, 0);

        // Duty extremes: ch2 div=1 high=1, ch1 div=10 high=0, applied while disabled
        en = 3'b001;
        send(2, 1, 1);
        step();
        chk("t4_acc2_pending", cfg_if.pending, 3'b100);
        chk("t4_acc2_error", cfg_if.cfg_error, 0);
        chk("t4_dis_clk", clk_out[2:1], 2'b00);
        chk("t4_dis_tick", tick[2:1], 2'b00);
        send(1, 10, 0);
        step();
        chk("t4_acc1_pending", cfg_if.pending, 3'b010);
        cfg_if.cfg_valid = 1'b0;
        step();
        chk("t4_applied_pending", cfg_if.pending, 3'b000);
        en = 3'b111;
        for (int j = 1; j <= 10; j++) begin
            step();
            chk($sformatf("t4_clk_j%0d", j), clk_out[2:1], 2'b10);
            chk($sformatf("t4_tick_j%0d", j), tick[2:1], {1'b1, (j == 10)});
        end

        // ch0 div=6 high=3 via its own wrap, then ch1 div=3 high=1 applied by sync
        send(0, 6, 3);
        step();
        chk("t5_acc0_pending", cfg_if.pending, 3'b001);
        cfg_if.cfg_valid = 1'b0;
        repeat (6) step();
        chk("t5_ch0_applied", cfg_if.pending, 3'b000);
        send(1, 3, 1);
        step();
        chk("t5_acc1_pending", cfg_if.pending, 3'b010);
        chk("t5_ready_blocked", cfg_if.cfg_ready, 0);
        cfg_if.cfg_valid = 1'b0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t5_sync_pending", cfg_if.pending, 3'b000);
        chk("t5_sync_tick", tick, 3'b000);
        chk("t5_sync_clk", clk_out, 3'b111);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("t5_clk_k%0d", k), clk_out,
                {1'b1, (((k - 1) % 3) == 0), (((k - 1) % 6) < 3)});
            chk($sformatf("t5_tick_k%0d", k), tick,
                {1'b1, (((k - 1) % 3) == 2), (((k - 1) % 6) == 5)});
        end
        send(0, 2, 1);
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("t6_pre_clk", clk_out, 3'b111);
        chk("t6_pre_tick", tick, 3'b100);
        chk("t6_pre_pending", cfg_if.pending, 3'b001);

        // Asynchronous reset mid-period, then defaults restored
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clk", clk_out, 3'b000);
        chk("t6_async_tick", tick, 3'b000);
        chk("t6_async_pending", cfg_if.pending, 3'b000);
        chk("t6_async_error", cfg_if.cfg_error, 0);
        #10;
        rst_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            b = ((n - 1) < 5);
            chk($sformatf("t6_def_clk_n%0d", n), clk_out, {b, b, b});
            b = (n == 10);
            chk($sformatf("t6_def_tick_n%0d", n), tick, {b, b, b});
        end
        chk("t6_def_pending", cfg_if.pending, 3'b000);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
